// File: rtl/gf2_conv.sv
// Sequential GF(2) polynomial multiplier: codeword = message(x) * generator(x), one bit per clock, MSB first.
// Build option GF2_CONV_SYSTEMATIC_EN: codeword = {message, message(x)*x^24 mod generator(x)}.
module gf2_conv (
  input  logic        clk,
  input  logic        resetN,
  input  logic        start,
  input  logic [39:0] message,
  input  logic [24:0] generator,
  output logic        busy,
  output logic        finish_flag,
  output logic [63:0] codeword
);

  // state | meaning
  // IDLE  | codeword valid, waiting for start
  // RUN   | stepping through the 40 message bits
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]  state;
  logic [39:0] msg_r;
  logic [5:0]  cnt;
  logic [63:0] codeword_r;
  logic        b;
  logic [39:0] msg_nxt;
  logic [63:0] result_nxt;

  assign b = msg_r[39];

`ifdef GF2_CONV_SYSTEMATIC_EN
  // The x^24 term of g is implicit, so only the low 24 bits are kept.
  logic [23:0] gen_r;
  logic [23:0] rem;
  logic [23:0] rem_nxt;
  logic        fb;

  // msg_r rotates so the original message is back in place after 40 steps.
  assign msg_nxt    = {msg_r[38:0], b};
  assign fb         = b ^ rem[23];
  assign rem_nxt    = {rem[22:0], 1'b0} ^ (fb ? gen_r : 24'd0);
  assign result_nxt = {msg_nxt, rem_nxt};

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      gen_r <= 24'd0;
      rem   <= 24'd0;
    end else if (start) begin
      gen_r <= generator[23:0];
      rem   <= 24'd0;
    end else if (state == RUN) begin
      rem   <= rem_nxt;
    end
  end
`else
  logic [24:0] gen_r;
  logic [63:0] acc;
  logic [63:0] acc_nxt;

  assign msg_nxt    = {msg_r[38:0], 1'b0};
  assign acc_nxt    = {acc[62:0], 1'b0} ^ (b ? {39'd0, gen_r} : 64'd0);
  assign result_nxt = acc_nxt;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      gen_r <= 25'd0;
      acc   <= 64'd0;
    end else if (start) begin
      gen_r <= generator;
      acc   <= 64'd0;
    end else if (state == RUN) begin
      acc   <= acc_nxt;
    end
  end
`endif

  // start wins in every state, so a restart silently abandons the running product.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      msg_r      <= 40'd0;
      cnt        <= 6'd0;
      codeword_r <= 64'd0;
    end else if (start) begin
      state      <= RUN;
      msg_r      <= message;
      cnt        <= 6'd40;
    end else if (state == RUN) begin
      msg_r <= msg_nxt;
      cnt   <= cnt - 6'd1;
      if (cnt == 6'd1) begin
        codeword_r <= result_nxt;
        state      <= IDLE;
      end
    end
  end

  assign busy        = (state == RUN);
  assign finish_flag = (state == IDLE);
  assign codeword    = codeword_r;

endmodule

// File: tb/tb_gf2_conv.sv
// Directed and round-trip bench for gf2_conv (non-systematic build).
module tb_gf2_conv;

  logic        clk = 1'b0;
  logic        resetN;
  logic        start;
  logic [39:0] message;
  logic [24:0] generator;
  logic        busy;
  logic        finish_flag;
  logic [63:0] codeword;

  int errors = 0;
  int checks = 0;
  logic [63:0] last_cw;

  gf2_conv dut (
    .clk         (clk),
    .resetN      (resetN),
    .start       (start),
    .message     (message),
    .generator   (generator),
    .busy        (busy),
    .finish_flag (finish_flag),
    .codeword    (codeword)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // LSB-first reference product
  function automatic logic [63:0] clmul(input logic [39:0] m, input logic [24:0] g);
    logic [63:0] c = 64'd0;
    for (int i = 0; i < 40; i++)
      if (m[i]) c ^= ({39'd0, g} << i);
    return c;
  endfunction

  // Downstream-style long division; g[24] must be 1
  task automatic gf2_div(input logic [63:0] c, input logic [24:0] g,
                         output logic [39:0] q, output logic [23:0] r);
    logic [63:0] w = c;
    q = 40'd0;
    for (int i = 63; i >= 24; i--) begin
      if (w[i]) begin
        q[i-24] = 1'b1;
        w ^= ({39'd0, g} << (i - 24));
      end
    end
    r = w[23:0];
  endtask

  // hold = number of edges with start high; latency counted from the last one
  task automatic run_op(input string tag, input logic [39:0] m, input logic [24:0] g,
                        input logic [63:0] exp, input int hold);
    @(negedge clk);
    message = m; generator = g; start = 1'b1;
    repeat (hold) @(posedge clk);
    #1 start = 1'b0;
    chk({tag, " busy@E0"}, {63'd0, busy}, 64'd1);
    chk({tag, " finish@E0"}, {63'd0, finish_flag}, 64'd0);
    repeat (39) @(posedge clk);
    #1;
    chk({tag, " finish@E39"}, {63'd0, finish_flag}, 64'd0);
    chk({tag, " hold@E39"}, codeword, last_cw);
    @(posedge clk);
    #1;
    chk({tag, " finish@E40"}, {63'd0, finish_flag}, 64'd1);
    chk({tag, " busy@E40"}, {63'd0, busy}, 64'd0);
    chk({tag, " codeword"}, codeword, exp);
    last_cw = exp;
  endtask

  initial begin
    logic [63:0] rnd;
    logic [39:0] m, q;
    logic [24:0] g;
    logic [23:0] r;

    resetN = 1'b0; start = 1'b0; message = 40'd0; generator = 25'd0;
    last_cw = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst finish", {63'd0, finish_flag}, 64'd1);
    chk("rst busy", {63'd0, busy}, 64'd0);
    chk("rst codeword", codeword, 64'd0);
    @(negedge clk) resetN = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("idle finish", {63'd0, finish_flag}, 64'd1);
    chk("idle busy", {63'd0, busy}, 64'd0);

    run_op("identity", 40'h1, 25'h1A2B3C5, 64'h0000_0000_01A2_B3C5, 1);
    run_op("topdeg", 40'h80_0000_0000, 25'h100_0000, 64'h8000_0000_0000_0000, 1);
    run_op("clmul3x3", 40'h3, 25'h3, 64'h5, 1);
    run_op("ffx3", 40'hFF, 25'h3, 64'h101, 1);
    run_op("gen0", 40'hFF_FFFF_FFFF, 25'h0, 64'h0, 1);
    run_op("identity2", 40'h1, 25'h1A2B3C5, 64'h0000_0000_01A2_B3C5, 1);
    run_op("msg0", 40'h0, 25'h1FF_FFFF, 64'h0, 1);
    run_op("identity3", 40'h1, 25'h1A2B3C5, 64'h0000_0000_01A2_B3C5, 1);

    // restart at step 20 of an abandoned operation
    @(negedge clk);
    message = 40'hFF; generator = 25'h3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(posedge clk);
    run_op("restart", 40'h3, 25'h3, 64'h5, 1);

    run_op("held5", 40'hFF, 25'h3, 64'h101, 5);

    // asynchronous reset mid-run
    @(negedge clk);
    message = 40'h1; generator = 25'h1A2B3C5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #3 resetN = 1'b0;
    #1;
    chk("midrst finish", {63'd0, finish_flag}, 64'd1);
    chk("midrst busy", {63'd0, busy}, 64'd0);
    chk("midrst codeword", codeword, 64'd0);
    @(negedge clk) resetN = 1'b1;
    repeat (45) @(posedge clk);
    #1;
    chk("postrst finish", {63'd0, finish_flag}, 64'd1);
    chk("postrst busy", {63'd0, busy}, 64'd0);
    chk("postrst codeword", codeword, 64'd0);
    last_cw = 64'd0;

    for (int n = 0; n < 200; n++) begin
      rnd = {$urandom(), $urandom()};
      m = rnd[39:0];
      g = {1'b1, rnd[63:40] ^ 24'($urandom())};
      run_op("rand", m, g, clmul(m, g), 1);
      gf2_div(codeword, g, q, r);
      chk("rt quotient", {24'd0, q}, {24'd0, m});
      chk("rt remainder", {40'd0, r}, 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
